// File: rtl/mux_sel_scanner.sv
// rtl/mux_sel_scanner.sv - walks the mux select over a window and packs the sampled bits
// Produces the captured word and its popcount on a valid/ready result port.
module mux_sel_scanner #(
  parameter int N_IN  = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] first_sel,
  input  logic [SEL_W:0]   count,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  data,
  output logic [SEL_W:0]   ones
);

  localparam logic [SEL_W:0]   FULL    = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W:0]   ONE     = (SEL_W+1)'(1);
  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t         state, state_nxt;
  logic [SEL_W:0] remaining;
  logic [SEL_W:0] idx;
  logic [SEL_W:0] eff_count;

  // Zero and anything past the mux width both mean a full sweep.
  always_comb begin
    eff_count = count;
    if (count == '0 || count > FULL) eff_count = FULL;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (remaining == ONE) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      remaining <= '0;
      idx       <= '0;
      data      <= '0;
      ones      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel       <= first_sel;
            remaining <= eff_count;
            idx       <= '0;
            data      <= '0;
            ones      <= '0;
          end
        end
        SCAN: begin
          // data is cleared on start, so OR-ing in the shifted sample sets bit idx.
          data      <= data | ({{(N_IN-1){1'b0}}, mux_in} << idx);
          ones      <= ones + {{SEL_W{1'b0}}, mux_in};
          idx       <= idx + ONE;
          remaining <= remaining - ONE;
          if (remaining > ONE) sel <= sel + SEL_ONE;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb/tb_mux_sel_scanner.sv - directed bench for mux_sel_scanner with a behavioural 16:1 mux
module tb_mux_sel_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  first_sel;
  logic [4:0]  count;
  logic [3:0]  sel;
  logic        mux_in;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data;
  logic [4:0]  ones;
  logic [15:0] in_bus = 16'h3F0A;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic [3:0] sel_log [0:16];

  always #5 clk = ~clk;

  assign mux_in = in_bus[sel];

  mux_sel_scanner #(.N_IN(16), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_sel(first_sel), .count(count),
    .sel(sel), .mux_in(mux_in), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .data(data), .ones(ones)
  );

  // Pulse start for one edge; returns at the negedge after the accepting edge.
  task automatic start_scan(input logic [3:0] fs, input logic [4:0] cnt);
    @(negedge clk);
    start = 1'b1; first_sel = fs; count = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Logs sel each cycle until out_valid; lat is cycles from start to out_valid.
  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 40) begin
      if (n < 17) sel_log[n] = sel;
      @(negedge clk);
      n++;
    end
    lat = n + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; first_sel = 4'h0; count = 5'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %h expected 0", sel); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data); end
    n_checks++; if (ones !== 5'd0) begin n_fail++; $display("FAIL reset_ones: got %0d expected 0", ones); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_scan();
    bit bad = 0;
    out_ready = 1'b1;
    start_scan(4'h0, 5'd0);
    n_checks++; if (sel !== 4'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL full_start: sel %h busy %b expected 0 1", sel, busy); end
    wait_valid();
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL full_latency: got %0d expected 17", lat); end
    for (int j = 0; j < 16; j++) if (sel_log[j] !== 4'(j)) bad = 1;
    n_checks++; if (bad) begin n_fail++; $display("FAIL full_sel_walk: last logged %h expected f", sel_log[15]); end
    n_checks++; if (data !== 16'h3F0A) begin n_fail++; $display("FAIL full_data: got %h expected 3f0a", data); end
    n_checks++; if (ones !== 5'd8) begin n_fail++; $display("FAIL full_ones: got %0d expected 8", ones); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL full_idle: busy %b valid %b expected 0 0", busy, out_valid); end
    n_checks++; if (data !== 16'h3F0A || ones !== 5'd8) begin n_fail++; $display("FAIL full_retain: data %h ones %0d expected 3f0a 8", data, ones); end
  endtask

  task automatic test_partial();
    bit bad = 0;
    out_ready = 1'b0;
    start_scan(4'h6, 5'd4);
    wait_valid();
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL partial_latency: got %0d expected 5", lat); end
    for (int j = 0; j < 4; j++) if (sel_log[j] !== 4'(6 + j)) bad = 1;
    n_checks++; if (bad) begin n_fail++; $display("FAIL partial_sel_walk: got %h %h %h %h expected 6 7 8 9", sel_log[0], sel_log[1], sel_log[2], sel_log[3]); end
    n_checks++; if (data !== 16'h000C || ones !== 5'd2) begin n_fail++; $display("FAIL partial_result: data %h ones %0d expected 000c 2", data, ones); end
    @(negedge clk);
    n_checks++; if (sel !== 4'h9 || out_valid !== 1'b1) begin n_fail++; $display("FAIL partial_hold: sel %h valid %b expected 9 1", sel, out_valid); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit bad = 0;
    out_ready = 1'b1;
    start_scan(4'hC, 5'd6);
    wait_valid();
    for (int j = 0; j < 6; j++) if (sel_log[j] !== 4'(12 + j)) bad = 1;
    n_checks++; if (bad) begin n_fail++; $display("FAIL wrap_sel_walk: got %h at step 4 expected 0", sel_log[4]); end
    n_checks++; if (data !== 16'h0023 || ones !== 5'd3) begin n_fail++; $display("FAIL wrap_result: data %h ones %0d expected 0023 3", data, ones); end
    n_checks++; if (lat != 7) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 7", lat); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit bad = 0;
    out_ready = 1'b0;
    start_scan(4'h0, 5'd20);
    wait_valid();
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL clamp_latency: got %0d expected 17", lat); end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin start = 1'b1; first_sel = 4'h5; count = 5'd3; end
      else start = 1'b0;
      @(negedge clk);
      if (out_valid !== 1'b1 || data !== 16'h3F0A || ones !== 5'd8 || sel !== 4'hF) bad = 1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL hold_stable: valid %b data %h ones %0d sel %h expected 1 3f0a 8 f", out_valid, data, ones, sel); end
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL handshake_idle: busy %b valid %b expected 0 0", busy, out_valid); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || sel !== 4'hF || data !== 16'h3F0A) begin n_fail++; $display("FAIL start_dropped: busy %b sel %h data %h expected 0 f 3f0a", busy, sel, data); end
  endtask

  task automatic test_reset_mid_scan();
    out_ready = 1'b1;
    start_scan(4'h0, 5'd0);
    repeat (7) @(negedge clk);
    n_checks++; if (sel !== 4'h7 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_scan_pos: sel %h busy %b expected 7 1", sel, busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (sel !== 4'h0 || busy !== 1'b0 || out_valid !== 1'b0 || data !== 16'h0 || ones !== 5'd0) begin
      n_fail++; $display("FAIL async_reset: sel %h busy %b valid %b data %h ones %0d expected all 0", sel, busy, out_valid, data, ones);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_scan(4'h8, 5'd6);
    wait_valid();
    n_checks++; if (data !== 16'h003F || ones !== 5'd6) begin n_fail++; $display("FAIL post_reset_scan: data %h ones %0d expected 003f 6", data, ones); end
    @(negedge clk);
  endtask

  task automatic test_single_bit();
    out_ready = 1'b0;
    start_scan(4'h1, 5'd1);
    wait_valid();
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", lat); end
    n_checks++; if (data !== 16'h0001 || ones !== 5'd1) begin n_fail++; $display("FAIL single_result: data %h ones %0d expected 0001 1", data, ones); end
    @(negedge clk);
    n_checks++; if (sel !== 4'h1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL single_hold: sel %h valid %b expected 1 1", sel, out_valid); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_partial();
    test_wrap();
    test_backpressure();
    test_reset_mid_scan();
    test_single_bit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
